// File: rtl/keccak_round_constants_lfsr.sv
// Keccak-f[1600] round-constant generator: produces the compressed 8-bit iota
// constant of each round from the rc(t) LFSR, stepped by a valid/next handshake.
module keccak_round_constants_lfsr #(
    parameter int unsigned NUM_ROUNDS = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       next_i,
    output logic [7:0] round_constant_signal_out,
    output logic [4:0] round_number_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        VALID
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [7:0] LFSR_SEED  = 8'h01;
    localparam logic [7:0] LFSR_TAPS  = 8'h71;

    state_t     state, state_next;
    logic [7:0] lfsr, lfsr_next, lfsr_stepped;
    logic [2:0] step, step_next, bit_index;
    logic [4:0] round, round_next;
    logic [7:0] work, work_next, work_with_bit;
    logic [7:0] constant_next;
    logic       valid_next, busy_next, done_next;

    // Galois form of x^8+x^6+x^5+x^4+1; R[0] is the rc(t) output bit.
    assign lfsr_stepped = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? LFSR_TAPS : 8'h00);

    // Step j carries RC bit 2^j-1; index 2 of the compressed form is unused.
    assign bit_index = (step < 3'd2) ? step : step + 3'd1;

    always_comb begin
        work_with_bit            = work;
        work_with_bit[bit_index] = lfsr[0];
    end

    always_comb begin
        state_next    = state;
        lfsr_next     = lfsr;
        step_next     = step;
        round_next    = round;
        work_next     = work;
        constant_next = round_constant_signal_out;
        valid_next    = valid_o;
        busy_next     = busy_o;
        done_next     = 1'b0;

        if (start_i) begin
            state_next    = GEN;
            lfsr_next     = LFSR_SEED;
            step_next     = '0;
            round_next    = '0;
            work_next     = '0;
            constant_next = '0;
            valid_next    = 1'b0;
            busy_next     = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                GEN: begin
                    work_next = work_with_bit;
                    lfsr_next = lfsr_stepped;
                    step_next = step + 3'd1;
                    if (step == 3'd6) begin
                        state_next    = VALID;
                        constant_next = work_with_bit;
                        valid_next    = 1'b1;
                    end
                end
                VALID: begin
                    if (next_i) begin
                        valid_next    = 1'b0;
                        constant_next = '0;
                        if (round == LAST_ROUND) begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            // LFSR keeps running across rounds; only a start reloads it.
                            state_next = GEN;
                            round_next = round + 5'd1;
                            step_next  = '0;
                            work_next  = '0;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                     <= IDLE;
            lfsr                      <= LFSR_SEED;
            step                      <= '0;
            round                     <= '0;
            work                      <= '0;
            round_constant_signal_out <= '0;
            valid_o                   <= 1'b0;
            busy_o                    <= 1'b0;
            done_o                    <= 1'b0;
        end else begin
            state                     <= state_next;
            lfsr                      <= lfsr_next;
            step                      <= step_next;
            round                     <= round_next;
            work                      <= work_next;
            round_constant_signal_out <= constant_next;
            valid_o                   <= valid_next;
            busy_o                    <= busy_next;
            done_o                    <= done_next;
        end
    end

    assign round_number_o = round;

endmodule

// File: tb/tb_keccak_round_constants_lfsr.sv
// Bench for keccak_round_constants_lfsr: directed passes plus randomized
// start/next traffic against a polynomial-arithmetic rc(t) reference.
module tb_keccak_round_constants_lfsr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, next = 1'b0;
    logic       start12 = 1'b0, next12 = 1'b0;
    logic [7:0] rc, rc12;
    logic [4:0] rn, rn12;
    logic       valid, busy, done, valid12, busy12, done12;

    always #5 clk = ~clk;

    keccak_round_constants_lfsr #(.NUM_ROUNDS(24)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .next_i(next),
        .round_constant_signal_out(rc), .round_number_o(rn),
        .valid_o(valid), .busy_o(busy), .done_o(done)
    );

    keccak_round_constants_lfsr #(.NUM_ROUNDS(12)) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start12), .next_i(next12),
        .round_constant_signal_out(rc12), .round_number_o(rn12),
        .valid_o(valid12), .busy_o(busy12), .done_o(done12)
    );

    logic [7:0] spec_tab [24] = '{8'h01, 8'h32, 8'hBA, 8'hE0, 8'h3B, 8'h41, 8'hF1, 8'hA9,
                                  8'h1A, 8'h18, 8'h69, 8'h4A, 8'h7B, 8'h9B, 8'hB9, 8'hA3,
                                  8'hA2, 8'h90, 8'h2A, 8'hCA, 8'hF1, 8'hB0, 8'h41, 8'hE8};

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rc(t) = constant term of x^t mod (x^8+x^6+x^5+x^4+1)
    function automatic logic rc_bit(input int unsigned t);
        logic [31:0] p = 32'd1;
        for (int unsigned i = 0; i < t % 255; i++) begin
            p = p << 1;
            if (p[8]) p = p ^ 32'h171;
        end
        return p[0];
    endfunction

    function automatic logic [7:0] ref_const(input int unsigned r);
        logic [63:0] rc64 = '0;
        for (int unsigned j = 0; j < 7; j++)
            rc64[(1 << j) - 1] = rc_bit(7 * r + j);
        return {rc64[63], rc64[31], rc64[15], rc64[7], rc64[3], 1'b0, rc64[1], rc64[0]};
    endfunction

    // Reference: phase 0 idle, 1 generating (cnt cycles elapsed), 2 holding constant
    int m_phase = 0, m_cnt = 0, m_round = 0;
    bit m_done = 0;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_round = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit s, input bit n);
        m_done = 0;
        if (s) begin
            m_phase = 1; m_cnt = 0; m_round = 0;
        end else if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == 7) m_phase = 2;
        end else if (m_phase == 2 && n) begin
            if (m_round == 23) begin
                m_phase = 0; m_done = 1;
            end else begin
                m_round++; m_phase = 1; m_cnt = 0;
            end
        end
    endtask

    task automatic check_all();
        check("valid", 32'(valid), 32'(m_phase == 2));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_done));
        check("round", 32'(rn), m_round);
        check("const", 32'(rc), (m_phase == 2) ? 32'(ref_const(m_round)) : 32'd0);
    endtask

    task automatic cyc(input bit s, input bit n);
        start = s; next = n;
        @(posedge clk);
        model_edge(s, n);
        @(negedge clk);
        start = 1'b0; next = 1'b0;
        check_all();
    endtask

    initial begin
        int unsigned cnt;
        bit found;
        int unsigned last_rn;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (10) cyc(0, 0);

        // Single start, constant held while next stays low
        cyc(1, 0);
        repeat (7) cyc(0, 0);
        check("first_const", 32'(rc), 32'(spec_tab[0]));
        repeat (20) cyc(0, 0);

        // Full pass with next tied high; start and next together -> start wins
        cyc(1, 1);
        cnt = 0; found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(0, 1);
            cnt++;
            if (valid && rn < 5'd24) begin
                check("pass_const", 32'(rc), 32'(spec_tab[rn]));
                check("idx2_clear", 32'(rc[2]), 32'd0);
            end
            if (done) found = 1;
        end
        check("pass_done_seen", 32'(found), 32'd1);
        check("pass_cycles", cnt, 32'd192);
        repeat (5) cyc(0, 1);

        // Stray next during GEN and in IDLE
        cyc(1, 0);
        repeat (6) cyc(0, 1);
        cyc(0, 0);
        check("stray_round0", 32'(rc), 32'h01);
        repeat (5) cyc(0, 1);

        // Restart while round 9 is valid
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(0, !(valid && rn == 5'd9));
            if (valid && rn == 5'd9) found = 1;
        end
        check("r9_seen", 32'(found), 32'd1);
        check("r9_const", 32'(rc), 32'h18);
        cyc(1, 0);
        check("restart_round", 32'(rn), 32'd0);
        repeat (7) cyc(0, 0);
        check("restart_const", 32'(rc), 32'h01);

        // Asynchronous reset in the middle of a pass
        repeat (20) cyc(0, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (3) cyc(0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc(($urandom % 60) == 0, ($urandom % 3) != 0);

        // NUM_ROUNDS = 12 instance, next tied high
        start12 = 1'b1; next12 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start12 = 1'b0;
        cnt = 0; found = 0; last_rn = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (valid12 && rn12 < 5'd24) begin
                check("p12_const", 32'(rc12), 32'(spec_tab[rn12]));
                last_rn = 32'(rn12);
            end
            if (done12) begin
                found = 1;
                check("p12_busy_fall", 32'(busy12), 32'd0);
            end
        end
        check("p12_done_seen", 32'(found), 32'd1);
        check("p12_cycles", cnt, 32'd96);
        check("p12_last_round", last_rn, 32'd11);
        @(posedge clk);
        @(negedge clk);
        check("p12_done_pulse", 32'(done12), 32'd0);
        next12 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
